// File: rtl/bird_turn_manager.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bird_turn_manager
//
// Turn sequencer for one level. Owns the bird inventory, places one bird at a
// time on the slingshot, fires it on a fresh press of the fire key, waits for
// the flight and a settle period, then declares the level won or lost or loads
// the next bird.
//
// Optional feature macro: BIRD_FLIGHT_TIMEOUT_EN
//   defined   -> a flight counter forces FLIGHT -> SETTLE after FLIGHT_TIMEOUT
//                cycles in flight, exactly like a landing.
//   undefined -> no counter; FLIGHT exits only on bird_landed[cur],
//                all_pigs_dead or start_level.
//
// Ports:
//   clk            in   system clock
//   resetN         in   asynchronous active-low reset
//   start_level    in   pulse: (re)start the level with a full inventory
//   fire_key       in   debounced fire key level
//   bird_landed    in   per-bird pulse: bird has stopped / left the screen
//   all_pigs_dead  in   level: no pigs remain
//   bird_load      out  one-hot level: bird currently on the slingshot
//   bird_shoot     out  one-hot single-cycle launch pulse
//   birds_left     out  birds not yet shot
//   level_won      out  held until start_level
//   level_lost     out  held until start_level
//   busy           out  high while a bird is in flight or settling
//   dbg_state      out  current FSM state encoding (state_t)
//
// Handshake: there is no valid/ready pair here. Inputs are levels or
// single-cycle pulses sampled on the rising clk edge; every output is a
// register loaded from the next-state values, so nothing combinational runs
// from an input to an output.
// -----------------------------------------------------------------------------
module bird_turn_manager #(
    parameter int NUM_BIRDS      = 3,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int FLIGHT_TIMEOUT = 16777215
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 start_level,
    input  logic                 fire_key,
    input  logic [NUM_BIRDS-1:0] bird_landed,
    input  logic                 all_pigs_dead,
    output logic [NUM_BIRDS-1:0] bird_load,
    output logic [NUM_BIRDS-1:0] bird_shoot,
    output logic [3:0]           birds_left,
    output logic                 level_won,
    output logic                 level_lost,
    output logic                 busy,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ARMED  = 3'd2,
        S_SHOOT  = 3'd3,
        S_FLIGHT = 3'd4,
        S_SETTLE = 3'd5,
        S_WON    = 3'd6,
        S_LOST   = 3'd7
    } state_t;

    localparam int CUR_W = (NUM_BIRDS > 1) ? $clog2(NUM_BIRDS) : 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [CUR_W-1:0]     CUR_LAST    = CUR_W'(NUM_BIRDS - 1);
    localparam logic [SET_W-1:0]     SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]           BIRDS_FULL  = 4'(NUM_BIRDS);
    localparam logic [NUM_BIRDS-1:0] ONE_HOT0    = NUM_BIRDS'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic [CUR_W-1:0]       cur_q, cur_d;
    logic                   fire_prev_q;
    logic [SET_W-1:0]       settle_cnt_q, settle_cnt_d;
    logic [3:0]             birds_left_q, birds_left_d;

    logic [NUM_BIRDS-1:0]   bird_load_q, bird_load_d;
    logic [NUM_BIRDS-1:0]   bird_shoot_q, bird_shoot_d;
    logic                   won_q, won_d;
    logic                   lost_q, lost_d;
    logic                   busy_q, busy_d;

    logic                   fire_rise;
    logic                   landed_cur;
    logic                   timeout_hit;

`ifdef BIRD_FLIGHT_TIMEOUT_EN
    localparam int FT_W = $clog2(FLIGHT_TIMEOUT + 1);
    localparam logic [FT_W-1:0] FT_LAST = FT_W'(FLIGHT_TIMEOUT - 1);

    logic [FT_W-1:0] flight_cnt_q, flight_cnt_d;

    // The counter is zero on the first FLIGHT cycle, so FT_LAST is seen on the
    // FLIGHT_TIMEOUT-th cycle in flight.
    assign timeout_hit = (flight_cnt_q == FT_LAST);
`else
    // Parameter kept for interface compatibility only.
    logic unused_flight_timeout;
    assign unused_flight_timeout = (FLIGHT_TIMEOUT == 0);
    assign timeout_hit = 1'b0;
`endif

    assign fire_rise  = fire_key & ~fire_prev_q;
    // Landing pulses from birds other than the one on the slingshot are
    // deliberately ignored.
    assign landed_cur = bird_landed[cur_q];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        settle_cnt_d = settle_cnt_q;
        birds_left_d = birds_left_q;
`ifdef BIRD_FLIGHT_TIMEOUT_EN
        flight_cnt_d = flight_cnt_q;
`endif

        if (start_level) begin
            // Restart wins over everything, including a bird mid-flight.
            state_d      = S_LOAD;
            cur_d        = '0;
            settle_cnt_d = '0;
            birds_left_d = BIRDS_FULL;
`ifdef BIRD_FLIGHT_TIMEOUT_EN
            flight_cnt_d = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_LOAD: begin
                    // Wait for key release so a held key never auto-fires.
                    if (!fire_key) state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (fire_rise) begin
                        state_d = S_SHOOT;
                        if (birds_left_q != 4'd0) birds_left_d = birds_left_q - 4'd1;
                    end
                end
                S_SHOOT: begin
                    state_d = S_FLIGHT;
`ifdef BIRD_FLIGHT_TIMEOUT_EN
                    flight_cnt_d = '0;
`endif
                end
                S_FLIGHT: begin
                    if (all_pigs_dead) begin
                        state_d = S_WON;
                    end else if (landed_cur || timeout_hit) begin
                        state_d      = S_SETTLE;
                        settle_cnt_d = '0;
                    end else begin
`ifdef BIRD_FLIGHT_TIMEOUT_EN
                        flight_cnt_d = flight_cnt_q + 1'b1;
`endif
                    end
                end
                S_SETTLE: begin
                    if (all_pigs_dead) begin
                        state_d = S_WON;
                    end else if (settle_cnt_q == SETTLE_LAST) begin
                        settle_cnt_d = '0;
                        if (birds_left_q == 4'd0) begin
                            state_d = S_LOST;
                        end else begin
                            state_d = S_LOAD;
                            // Never wraps: a bird remains, so cur < last.
                            if (cur_q != CUR_LAST) cur_d = cur_q + 1'b1;
                        end
                    end else begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                    end
                end
                S_WON:   state_d = S_WON;
                S_LOST:  state_d = S_LOST;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output next values, decoded from the next state so that the
    // registered outputs line up with the state they describe.
    // ------------------------------------------------------------------
    always_comb begin
        bird_load_d  = '0;
        bird_shoot_d = '0;
        won_d        = 1'b0;
        lost_d       = 1'b0;
        busy_d       = 1'b0;

        case (state_d)
            S_LOAD, S_ARMED: bird_load_d = ONE_HOT0 << cur_d;
            S_SHOOT: begin
                bird_load_d  = ONE_HOT0 << cur_d;
                bird_shoot_d = ONE_HOT0 << cur_d;
            end
            S_FLIGHT, S_SETTLE: busy_d = 1'b1;
            S_WON:   won_d  = 1'b1;
            S_LOST:  lost_d = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= S_IDLE;
            cur_q        <= '0;
            fire_prev_q  <= 1'b0;
            settle_cnt_q <= '0;
            birds_left_q <= 4'd0;
            bird_load_q  <= '0;
            bird_shoot_q <= '0;
            won_q        <= 1'b0;
            lost_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            fire_prev_q  <= fire_key;
            settle_cnt_q <= settle_cnt_d;
            birds_left_q <= birds_left_d;
            bird_load_q  <= bird_load_d;
            bird_shoot_q <= bird_shoot_d;
            won_q        <= won_d;
            lost_q       <= lost_d;
            busy_q       <= busy_d;
        end
    end

`ifdef BIRD_FLIGHT_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            flight_cnt_q <= '0;
        end else begin
            flight_cnt_q <= flight_cnt_d;
        end
    end
`endif

    assign bird_load  = bird_load_q;
    assign bird_shoot = bird_shoot_q;
    assign birds_left = birds_left_q;
    assign level_won  = won_q;
    assign level_lost = lost_q;
    assign busy       = busy_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_bird_turn_manager.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_bird_turn_manager
//
// Directed bench for bird_turn_manager with a short settle period. A table of
// {inputs, expected outputs} records drives the first turn cycle by cycle;
// hand-written sequences cover held keys, settle timing, losing, winning and
// restarting mid-flight.
// -----------------------------------------------------------------------------
module tb_bird_turn_manager;

    localparam int NB = 3;
    localparam int SC = 10;
    localparam int FT = 20;
`ifdef BIRD_FLIGHT_TIMEOUT_EN
    localparam int HOLD = 15;
`else
    localparam int HOLD = 100;
`endif

    // ---------------- clock / reset ----------------
    logic          clk;
    logic          resetN;
    logic          start_level;
    logic          fire_key;
    logic [NB-1:0] bird_landed;
    logic          all_pigs_dead;
    logic [NB-1:0] bird_load;
    logic [NB-1:0] bird_shoot;
    logic [3:0]    birds_left;
    logic          level_won;
    logic          level_lost;
    logic          busy;
    logic [2:0]    dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bird_turn_manager #(
        .NUM_BIRDS      (NB),
        .SETTLE_CYCLES  (SC),
        .FLIGHT_TIMEOUT (FT)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .start_level   (start_level),
        .fire_key      (fire_key),
        .bird_landed   (bird_landed),
        .all_pigs_dead (all_pigs_dead),
        .bird_load     (bird_load),
        .bird_shoot    (bird_shoot),
        .birds_left    (birds_left),
        .level_won     (level_won),
        .level_lost    (level_lost),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    // ---------------- scoreboard ----------------
    // Packed expectation: {load[2:0], shoot[2:0], left[3:0], won, lost, busy}
    logic [12:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [12:0] pk(input logic [2:0] ld, input logic [2:0] sh,
                                       input logic [3:0] left, input logic w,
                                       input logic l, input logic b);
        return {ld, sh, left, w, l, b};
    endfunction

    task automatic cmp(input string nm);
        logic [12:0] e;
        logic [12:0] a;
        a = {bird_load, bird_shoot, birds_left, level_won, level_lost, busy};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: expectation queue empty", nm);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_errors++;
                $display("FAIL %s: got load=%b shoot=%b left=%0d won=%b lost=%b busy=%b, expected load=%b shoot=%b left=%0d won=%b lost=%b busy=%b",
                         nm, a[12:10], a[9:7], a[6:3], a[2], a[1], a[0],
                         e[12:10], e[9:7], e[6:3], e[2], e[1], e[0]);
            end
        end
    endtask

    task automatic check(input string nm, input logic [12:0] e);
        exp_q.push_back(e);
        cmp(nm);
    endtask

    // ---------------- driver ----------------
    // Inputs change 1ns after a rising edge, are sampled at the next edge,
    // and outputs are compared 1ns after that edge.
    task automatic step(input logic st, input logic fi, input logic [2:0] ld, input logic pg);
        start_level   = st;
        fire_key      = fi;
        bird_landed   = ld;
        all_pigs_dead = pg;
        @(posedge clk);
        #1;
    endtask

    // From LOAD (key released): arm, fire, fly, land, settle, decide.
    task automatic play_bird(input int idx, input logic [3:0] left_before,
                             input logic [12:0] after_settle);
        logic [2:0] oh;
        logic [3:0] left_after;
        oh = 3'b001 << idx;
        left_after = left_before - 4'd1;
        step(1'b0, 1'b0, 3'b000, 1'b0);
        check("armed", pk(oh, 3'b000, left_before, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b1, 3'b000, 1'b0);
        check("shoot", pk(oh, oh, left_after, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b0, 3'b000, 1'b0);
        check("flight", pk(3'b000, 3'b000, left_after, 1'b0, 1'b0, 1'b1));
        step(1'b0, 1'b0, oh, 1'b0);
        check("landed", pk(3'b000, 3'b000, left_after, 1'b0, 1'b0, 1'b1));
        for (int k = 1; k < SC; k++) begin
            step(1'b0, 1'b0, 3'b000, 1'b0);
            check("settle", pk(3'b000, 3'b000, left_after, 1'b0, 1'b0, 1'b1));
        end
        step(1'b0, 1'b0, 3'b000, 1'b0);
        check("decide", after_settle);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        start;
        logic        fire;
        logic [2:0]  landed;
        logic        pigs;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[7];

    initial begin
        // start, fire, landed, pigs -> expected outputs after the edge
        tbl[0] = '{1'b1, 1'b0, 3'b000, 1'b0, pk(3'b001, 3'b000, 4'd3, 1'b0, 1'b0, 1'b0)}; // LOAD
        tbl[1] = '{1'b0, 1'b0, 3'b000, 1'b0, pk(3'b001, 3'b000, 4'd3, 1'b0, 1'b0, 1'b0)}; // ARMED
        tbl[2] = '{1'b0, 1'b0, 3'b001, 1'b0, pk(3'b001, 3'b000, 4'd3, 1'b0, 1'b0, 1'b0)}; // landing ignored
        tbl[3] = '{1'b0, 1'b1, 3'b000, 1'b0, pk(3'b001, 3'b001, 4'd2, 1'b0, 1'b0, 1'b0)}; // SHOOT
        tbl[4] = '{1'b0, 1'b1, 3'b000, 1'b0, pk(3'b000, 3'b000, 4'd2, 1'b0, 1'b0, 1'b1)}; // FLIGHT
        tbl[5] = '{1'b0, 1'b1, 3'b100, 1'b0, pk(3'b000, 3'b000, 4'd2, 1'b0, 1'b0, 1'b1)}; // stray bird 2
        tbl[6] = '{1'b0, 1'b1, 3'b010, 1'b0, pk(3'b000, 3'b000, 4'd2, 1'b0, 1'b0, 1'b1)}; // stray bird 1

        // ---------------- reset ----------------
        resetN        = 1'b0;
        start_level   = 1'b0;
        fire_key      = 1'b0;
        bird_landed   = 3'b000;
        all_pigs_dead = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", pk(3'b000, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0));
        n_checks++;
        if (dbg_state !== 3'd0) begin
            n_errors++;
            $display("FAIL reset_state: got %0d expected 0", dbg_state);
        end
        resetN = 1'b1;
        step(1'b0, 1'b1, 3'b001, 1'b1);
        check("idle", pk(3'b000, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0));

        // ---------------- table: first turn ----------------
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(tbl[i].exp);
            step(tbl[i].start, tbl[i].fire, tbl[i].landed, tbl[i].pigs);
            cmp($sformatf("vec%0d", i));
        end

        // Held key during flight: no further shot.
        for (int i = 0; i < HOLD; i++) begin
            step(1'b0, 1'b1, 3'b000, 1'b0);
            check("hold_fire", pk(3'b000, 3'b000, 4'd2, 1'b0, 1'b0, 1'b1));
        end

        // Land bird 0 and settle exactly SC cycles.
        step(1'b0, 1'b0, 3'b001, 1'b0);
        check("land0", pk(3'b000, 3'b000, 4'd2, 1'b0, 1'b0, 1'b1));
        for (int k = 1; k < SC; k++) begin
            step(1'b0, 1'b0, 3'b000, 1'b0);
            check("settle0", pk(3'b000, 3'b000, 4'd2, 1'b0, 1'b0, 1'b1));
        end
        step(1'b0, 1'b0, 3'b000, 1'b0);
        check("load1", pk(3'b010, 3'b000, 4'd2, 1'b0, 1'b0, 1'b0));

        // Remaining birds, no pigs killed -> lost.
        play_bird(1, 4'd2, pk(3'b100, 3'b000, 4'd1, 1'b0, 1'b0, 1'b0));
        play_bird(2, 4'd1, pk(3'b000, 3'b000, 4'd0, 1'b0, 1'b1, 1'b0));
        step(1'b0, 1'b1, 3'b000, 1'b0);
        check("lost_hold", pk(3'b000, 3'b000, 4'd0, 1'b0, 1'b1, 1'b0));
        step(1'b0, 1'b0, 3'b100, 1'b0);
        check("lost_hold2", pk(3'b000, 3'b000, 4'd0, 1'b0, 1'b1, 1'b0));

        // ---------------- won during second flight ----------------
        step(1'b1, 1'b0, 3'b000, 1'b0);
        check("restart", pk(3'b001, 3'b000, 4'd3, 1'b0, 1'b0, 1'b0));
        play_bird(0, 4'd3, pk(3'b010, 3'b000, 4'd2, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b0, 3'b000, 1'b0);
        check("armed_w", pk(3'b010, 3'b000, 4'd2, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b1, 3'b000, 1'b0);
        check("shoot_w", pk(3'b010, 3'b010, 4'd1, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b0, 3'b000, 1'b0);
        check("flight_w", pk(3'b000, 3'b000, 4'd1, 1'b0, 1'b0, 1'b1));
        // Pigs dead and landing in the same cycle: win has priority.
        step(1'b0, 1'b0, 3'b010, 1'b1);
        check("won", pk(3'b000, 3'b000, 4'd1, 1'b1, 1'b0, 1'b0));
        step(1'b0, 1'b1, 3'b000, 1'b0);
        check("won_hold", pk(3'b000, 3'b000, 4'd1, 1'b1, 1'b0, 1'b0));

        // ---------------- restart mid-flight with key held ----------------
        step(1'b1, 1'b0, 3'b000, 1'b0);
        check("restart2", pk(3'b001, 3'b000, 4'd3, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b0, 3'b000, 1'b0);
        check("armed_r", pk(3'b001, 3'b000, 4'd3, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b1, 3'b000, 1'b0);
        check("shoot_r", pk(3'b001, 3'b001, 4'd2, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b1, 3'b000, 1'b0);
        check("flight_r", pk(3'b000, 3'b000, 4'd2, 1'b0, 1'b0, 1'b1));
        step(1'b1, 1'b1, 3'b000, 1'b0);
        check("restart_mid", pk(3'b001, 3'b000, 4'd3, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 3'b000, 1'b0);
            check("held_no_fire", pk(3'b001, 3'b000, 4'd3, 1'b0, 1'b0, 1'b0));
        end
        step(1'b0, 1'b0, 3'b000, 1'b0);
        check("release", pk(3'b001, 3'b000, 4'd3, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b1, 3'b000, 1'b0);
        check("repress", pk(3'b001, 3'b001, 4'd2, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b0, 3'b000, 1'b0);
        check("flight_t", pk(3'b000, 3'b000, 4'd2, 1'b0, 1'b0, 1'b1));

`ifdef BIRD_FLIGHT_TIMEOUT_EN
        // Never land: FLIGHT lasts FT cycles, then settles as if landed.
        for (int k = 1; k < FT; k++) begin
            step(1'b0, 1'b0, 3'b000, 1'b0);
            check("to_flight", pk(3'b000, 3'b000, 4'd2, 1'b0, 1'b0, 1'b1));
        end
        step(1'b0, 1'b0, 3'b000, 1'b0);
        check("to_settle", pk(3'b000, 3'b000, 4'd2, 1'b0, 1'b0, 1'b1));
        for (int k = 1; k < SC; k++) begin
            step(1'b0, 1'b0, 3'b000, 1'b0);
            check("to_settle_n", pk(3'b000, 3'b000, 4'd2, 1'b0, 1'b0, 1'b1));
        end
        step(1'b0, 1'b0, 3'b000, 1'b0);
        check("to_load1", pk(3'b010, 3'b000, 4'd2, 1'b0, 1'b0, 1'b0));
`else
        // Without the timeout, a bird that never lands keeps the FSM in flight.
        for (int k = 0; k < FT + 5; k++) begin
            step(1'b0, 1'b0, 3'b000, 1'b0);
            check("no_timeout", pk(3'b000, 3'b000, 4'd2, 1'b0, 1'b0, 1'b1));
        end
`endif

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bird_turn_manager.md
# bird_turn_manager

Turn sequencer for one Angry Birds level. It owns the bird inventory and places one bird at a time on the slingshot. On each fresh press of the fire key it issues a single-cycle shoot pulse, then waits for that bird to finish its flight and a settle period. It then declares the level won or lost, or loads the next bird. It sits between the debounced key interface and the per-bird motion modules, and feeds the score/HUD logic.

## Interface
- NUM_BIRDS, 3: birds per level, legal 1..8.
- SETTLE_CYCLES, 1000: clk cycles to wait after a flight ends before the next decision, ≥1.
- FLIGHT_TIMEOUT, 16777215: maximum clk cycles in flight before a forced end. Used only with BIRD_FLIGHT_TIMEOUT_EN.
- clk  in  1  system clock.
- resetN  in  1  reset resetN, asynchronous, active-low; clock clk.
- start_level  in  1  single-cycle pulse: (re)start the level with a full inventory.
- fire_key  in  1  debounced fire key level (Enter).
- bird_landed  in  NUM_BIRDS  per-bird pulse: the bird has stopped or left the screen.
- all_pigs_dead  in  1  level: no pigs remain.
- bird_load  out  NUM_BIRDS  one-hot level marking the bird on the slingshot.
- bird_shoot  out  NUM_BIRDS  one-hot single-cycle launch pulse.
- birds_left  out  4  birds not yet shot.
- level_won  out  1  level, held until start_level.
- level_lost  out  1  level, held until start_level.
- busy  out  1  high in FLIGHT and SETTLE.

## Operation
- States and transitions:
  - IDLE: wait for start_level.
  - LOAD: go to ARMED once fire_key = 0, so a held key never auto-fires.
  - ARMED: go to SHOOT on a fire rising edge.
  - SHOOT: lasts one cycle, then FLIGHT.
  - FLIGHT: leave on bird_landed[cur], or on timeout when enabled.
  - SETTLE: count SETTLE_CYCLES, then decide.
  - WON / LOST: terminal; wait for start_level.
- Rising-edge detect: fire_prev is registered every cycle; rise = fire_key & ~fire_prev.
- cur is the current bird index, 0..NUM_BIRDS-1. It resets to 0 on start_level and increments only on SETTLE→LOAD. It never wraps within a level.
- start_level in any state, including mid-flight:
  - birds_left ← NUM_BIRDS, cur ← 0, settle/timeout counters cleared.
  - won/lost cleared, next state LOAD.
- birds_left decrements on the edge that enters SHOOT. It saturates at 0.
- SETTLE decision, in priority order:
  - all_pigs_dead → WON;
  - birds_left = 0 → LOST;
  - else cur+1 → LOAD.
- all_pigs_dead high in FLIGHT or SETTLE goes to WON on the next edge. This has priority over bird_landed in the same cycle.
- bird_landed bits for birds other than cur are ignored.
- Any bird_landed seen outside FLIGHT is ignored.
- bird_load[cur] is high in LOAD, ARMED and SHOOT; all bits are 0 otherwise.
- Illegal state encoding → IDLE.

## Timing
- Reset values:
  - Internal: state IDLE, cur 0, fire_prev 0, counters 0.
  - Outputs: birds_left 0, bird_load 0, bird_shoot 0, level_won 0, level_lost 0, busy 0.
- All outputs are registered. No combinational path from any input to any output.
- Fire latency: rise sampled at edge N in ARMED → bird_shoot[cur] high for exactly the cycle following edge N → cleared at edge N+1.
- bird_landed[cur] sampled at edge M in FLIGHT → SETTLE from edge M. The SETTLE→LOAD/WON/LOST transition occurs at edge M+SETTLE_CYCLES.
- start_level → bird_load[0] high one cycle later, provided fire_key = 0.
- At most one bird_shoot bit is ever high. Shots are never closer together than SETTLE_CYCLES+3 cycles.

## Configuration
- BIRD_FLIGHT_TIMEOUT_EN defined:
  - A flight counter clears on entry to FLIGHT.
  - When it reaches FLIGHT_TIMEOUT, FLIGHT → SETTLE exactly as a landing would.
- BIRD_FLIGHT_TIMEOUT_EN undefined:
  - No counter is built and FLIGHT_TIMEOUT is unused.
  - FLIGHT exits only on bird_landed[cur], all_pigs_dead, or start_level.

## Test plan
- Reset, then start_level with fire_key=0 → bird_load=3'b001, birds_left=3, all other outputs 0.
- Fire pulse in ARMED → bird_shoot=3'b001 for exactly 1 cycle, birds_left=2, busy=1. Hold fire_key for 100 cycles → no further shoot.
- bird_landed[0], wait SETTLE_CYCLES → bird_load=3'b010. Stray bird_landed[2] during FLIGHT → no effect.
- Shoot and land all 3 birds with all_pigs_dead=0 → level_lost=1, birds_left=0. Repeat with all_pigs_dead asserted during the 2nd flight → level_won=1 on the next edge, birds_left=1.
- start_level mid-FLIGHT → LOAD, birds_left=3, bird_load=3'b001. Hold fire_key high through start_level → no shot until release and re-press.
- With BIRD_FLIGHT_TIMEOUT_EN and FLIGHT_TIMEOUT=20, never land → SETTLE entered 20 cycles after SHOOT, next bird loaded.
